// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: pipeline issue, multdiv handshake and writeback signals of the multdiv sequencer
interface multdiv_ctrl_if #(
  parameter int RD_WIDTH = 5
);
  logic                issue_valid;
  logic                issue_isDiv;
  logic [31:0]         issue_opA;
  logic [15:0]         issue_opB;
  logic [RD_WIDTH-1:0] issue_rd;
  logic                stall;
  logic                busy;
  logic [31:0]         md_operandA;
  logic [15:0]         md_operandB;
  logic                md_ctrl_MULT;
  logic                md_ctrl_DIV;
  logic [31:0]         md_result;
  logic                md_exception;
  logic                md_inputRDY;
  logic                md_resultRDY;
  logic                wb_valid;
  logic [RD_WIDTH-1:0] wb_rd;
  logic [31:0]         wb_data;
  logic                wb_exception;
  modport master (
    input  issue_valid, issue_isDiv, issue_opA, issue_opB, issue_rd,
    input  md_result, md_exception, md_inputRDY, md_resultRDY,
    output stall, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data, wb_exception
  );
  modport slave (
    output issue_valid, issue_isDiv, issue_opA, issue_opB, issue_rd,
    output md_result, md_exception, md_inputRDY, md_resultRDY,
    input  stall, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, wb_exception
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div op through multdiv with stall, div-by-zero trap and timeout
module multdiv_ctrl #(
  parameter  int TIMEOUT_CYCLES = 64,
  parameter  int RD_WIDTH       = 5,
  localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input logic          clock,
  input logic          ctrl_reset,
  multdiv_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t              state, state_nx;
  logic [31:0]         op_a, res_q;
  logic [15:0]         op_b;
  logic [RD_WIDTH-1:0] rd_q;
  logic                div_q, exc_q;
  logic [TW-1:0]       timer;
  logic                div_zero, timeout;
  assign div_zero = bus.issue_isDiv && bus.issue_opB == '0;
  assign timeout  = timer == TW'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) state <= IDLE;
    else            state <= state_nx;
  // next state: div-by-zero skips multdiv entirely; a result beats a same-cycle timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.issue_valid && (div_zero || bus.md_inputRDY)) state_nx = div_zero ? DONE : ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (bus.md_resultRDY || timeout) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end
  // operand, tag, result and timer capture
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) begin
      op_a  <= '0;
      op_b  <= '0;
      rd_q  <= '0;
      div_q <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (bus.issue_valid) begin
          if (div_zero) begin
            rd_q  <= bus.issue_rd;
            res_q <= '0;
            exc_q <= 1'b1;
          end else if (bus.md_inputRDY) begin
            op_a  <= bus.issue_opA;
            op_b  <= bus.issue_opB;
            rd_q  <= bus.issue_rd;
            div_q <= bus.issue_isDiv;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (bus.md_resultRDY) begin
            res_q <= bus.md_exception ? '0 : bus.md_result;
            exc_q <= bus.md_exception;
          end else if (timeout) begin
            res_q <= '0;
            exc_q <= 1'b1;
          end
        end
        DONE: begin
          op_a <= '0;
          op_b <= '0;
        end
      endcase
    end
  // outputs decoded from registered state; stall alone looks at issue_valid while idle
  always_comb begin
    bus.stall        = state == IDLE ? bus.issue_valid : state != DONE;
    bus.busy         = state != IDLE;
    bus.md_operandA  = (state == ISSUE || state == WAIT) ? op_a : '0;
    bus.md_operandB  = (state == ISSUE || state == WAIT) ? op_b : '0;
    bus.md_ctrl_MULT = state == ISSUE && !div_q;
    bus.md_ctrl_DIV  = state == ISSUE && div_q;
    bus.wb_valid     = state == DONE;
    bus.wb_rd        = state == DONE ? rd_q : '0;
    bus.wb_data      = state == DONE ? res_q : '0;
    bus.wb_exception = state == DONE && exc_q;
  end
endmodule
